// File: rtl/load_memory_interface.sv
// rv32i load path, memory side: word-aligned read, lane extraction, sign/zero extension, bounded wait.
// Optional macro LOAD_MISALIGN_TRAP_EN: misaligned LH/LHU/LW return an error without touching memory.
module load_memory_interface #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_address,
  input  logic [2:0]  req_funct3,
  output logic        mem_read_enable,
  output logic [31:0] mem_read_address,
  input  logic        mem_read_ready,
  input  logic [31:0] mem_read_value,
  output logic        rsp_valid,
  output logic [31:0] rsp_value,
  output logic        rsp_error
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  count;
  logic [1:0]  lane;
  logic [2:0]  funct3;
  logic        legal;
  logic        misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] extracted;

  always_comb begin
    legal = (req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2) ||
            (req_funct3 == 3'd4) || (req_funct3 == 3'd5);
`ifdef LOAD_MISALIGN_TRAP_EN
    misaligned = (((req_funct3 == 3'd1) || (req_funct3 == 3'd5)) && req_address[0]) ||
                 ((req_funct3 == 3'd2) && (req_address[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
  end

  // Lane select uses the captured address bits; the word arrives while the request is long gone.
  always_comb begin
    case (lane)
      2'd0:    byte_sel = mem_read_value[7:0];
      2'd1:    byte_sel = mem_read_value[15:8];
      2'd2:    byte_sel = mem_read_value[23:16];
      default: byte_sel = mem_read_value[31:24];
    endcase
    half_sel = lane[1] ? mem_read_value[31:16] : mem_read_value[15:0];
    case (funct3)
      3'd0:    extracted = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    extracted = {{16{half_sel[15]}}, half_sel};
      3'd4:    extracted = {24'd0, byte_sel};
      3'd5:    extracted = {16'd0, half_sel};
      default: extracted = mem_read_value;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      req_ready        <= 1'b1;
      mem_read_enable  <= 1'b0;
      mem_read_address <= 32'd0;
      rsp_valid        <= 1'b0;
      rsp_value        <= 32'd0;
      rsp_error        <= 1'b0;
      count            <= 8'd0;
      lane             <= 2'd0;
      funct3           <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lane      <= req_address[1:0];
            funct3    <= req_funct3;
            req_ready <= 1'b0;
            if (!legal || misaligned) begin
              state     <= RESPOND;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_value <= 32'd0;
            end else begin
              state            <= ACCESS;
              mem_read_enable  <= 1'b1;
              mem_read_address <= {req_address[31:2], 2'b00};
            end
          end
        end
        ACCESS: begin
          // Data arriving on the last allowed cycle still counts as a good response.
          if (mem_read_ready) begin
            state           <= RESPOND;
            mem_read_enable <= 1'b0;
            rsp_valid       <= 1'b1;
            rsp_error       <= 1'b0;
            rsp_value       <= extracted;
            count           <= 8'd0;
          end else if (count == LAST_COUNT) begin
            state           <= RESPOND;
            mem_read_enable <= 1'b0;
            rsp_valid       <= 1'b1;
            rsp_error       <= 1'b1;
            rsp_value       <= 32'd0;
            count           <= 8'd0;
          end else begin
            count <= count + 8'd1;
          end
        end
        RESPOND: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          count     <= 8'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_memory_interface.sv
// Randomized and directed bench for load_memory_interface, checked against a behavioural load model.
module tb_load_memory_interface;
  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_address = 32'd0;
  logic [2:0]  req_funct3 = 3'd0;
  logic        mem_read_enable;
  logic [31:0] mem_read_address;
  logic        mem_read_ready = 1'b0;
  logic [31:0] mem_read_value = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_value;
  logic        rsp_error;

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  load_memory_interface #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address), .req_funct3(req_funct3),
    .mem_read_enable(mem_read_enable), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_value(mem_read_value),
    .rsp_valid(rsp_valid), .rsp_value(rsp_value), .rsp_error(rsp_error)
  );

  // Reference: what a load should return, how long it takes, how many cycles memory is asked.
  // dly = number of enabled cycles memory stays silent before answering (>= TO: never answers).
  function automatic void model(input logic [31:0] a, input logic [2:0] f, input logic [31:0] w,
                                input int dly, output logic [31:0] v, output logic e,
                                output int lat, output int en);
    logic [31:0] b, h;
    logic bad;
    bad = !(f == 0 || f == 1 || f == 2 || f == 4 || f == 5);
`ifdef LOAD_MISALIGN_TRAP_EN
    if ((f == 1 || f == 5) && (a % 2 != 0)) bad = 1'b1;
    if (f == 2 && (a % 4 != 0)) bad = 1'b1;
`endif
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    if (bad) begin
      v = 0; e = 1; lat = 1; en = 0;
    end else if (dly >= TO) begin
      v = 0; e = 1; lat = TO + 1; en = TO;
    end else begin
      e = 0; lat = dly + 2; en = dly + 1;
      case (f)
        3'd0:    v = (b >= 128) ? b - 32'd256 : b;
        3'd1:    v = (h >= 32768) ? h - 32'd65536 : h;
        3'd4:    v = b;
        3'd5:    v = h;
        default: v = w;
      endcase
    end
  endfunction

  // Issue one load and act as memory; report what the DUT did.
  task automatic do_load(input logic [31:0] a, input logic [2:0] f, input logic [31:0] w,
                         input int dly, output logic acc_rdy, output int lat, output int en,
                         output logic [31:0] v, output logic e, output logic [31:0] ra,
                         output logic post_valid, output logic post_ready);
    bit got = 0;
    lat = 0; en = 0; v = 'x; e = 'x; ra = 32'd0;
    @(negedge clock);
    acc_rdy = req_ready;
    req_valid = 1'b1; req_address = a; req_funct3 = f;
    @(posedge clock); #1;
    req_valid = 1'b0; req_address = $urandom;
    while (!got && lat < 40) begin
      @(negedge clock);
      lat++;
      if (rsp_valid) begin
        got = 1; v = rsp_value; e = rsp_error;
      end else if (mem_read_enable) begin
        ra = mem_read_address;
        mem_read_ready = (en == dly);
        mem_read_value = (en == dly) ? w : $urandom;
        en++;
      end else begin
        mem_read_ready = 1'b0;
      end
    end
    mem_read_ready = 1'b0;
    @(negedge clock);
    post_valid = rsp_valid;
    post_ready = req_ready;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++; if ({req_ready, mem_read_enable, rsp_valid, rsp_error} !== 4'b1000)
      $display("FAIL reset_ctrl: got %b want 1000", {req_ready, mem_read_enable, rsp_valid, rsp_error});
    else passes++;
    checks++; if ({mem_read_address, rsp_value} !== 64'd0)
      $display("FAIL reset_data: got %h want 0", {mem_read_address, rsp_value});
    else passes++;
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic r, e, pv, pr; int lat, en; logic [31:0] v, ra;
    do_load(32'h103, 3'd0, 32'h80FF_1234, 0, r, lat, en, v, e, ra, pv, pr);
    checks++; if (v !== 32'hFFFF_FF80 || e !== 1'b0) $display("FAIL lb_103: got %h/%b want ffffff80/0", v, e); else passes++;
    checks++; if (lat !== 2) $display("FAIL lb_latency: got %0d want 2", lat); else passes++;
    checks++; if (ra !== 32'h100) $display("FAIL lb_addr: got %h want 00000100", ra); else passes++;
    checks++; if (pv !== 1'b0 || pr !== 1'b1) $display("FAIL lb_pulse: got %b%b want 01", pv, pr); else passes++;
    do_load(32'h102, 3'd5, 32'h8001_7FFF, 1, r, lat, en, v, e, ra, pv, pr);
    checks++; if (v !== 32'h0000_8001) $display("FAIL lhu_102: got %h want 00008001", v); else passes++;
    do_load(32'h102, 3'd1, 32'h8001_7FFF, 0, r, lat, en, v, e, ra, pv, pr);
    checks++; if (v !== 32'hFFFF_8001) $display("FAIL lh_102: got %h want ffff8001", v); else passes++;
    do_load(32'h100, 3'd2, 32'h8001_7FFF, 2, r, lat, en, v, e, ra, pv, pr);
    checks++; if (v !== 32'h8001_7FFF || lat !== 4) $display("FAIL lw_100: got %h lat %0d want 80017fff lat 4", v, lat); else passes++;
    do_load(32'h100, 3'd3, 32'h1234_5678, 0, r, lat, en, v, e, ra, pv, pr);
    checks++; if (e !== 1'b1 || v !== 32'd0 || en !== 0 || lat !== 1)
      $display("FAIL bad_funct3: got e=%b v=%h en=%0d lat=%0d want 1 0 0 1", e, v, en, lat);
    else passes++;
    do_load(32'h101, 3'd2, 32'hCAFE_F00D, 0, r, lat, en, v, e, ra, pv, pr);
`ifdef LOAD_MISALIGN_TRAP_EN
    checks++; if (e !== 1'b1 || v !== 32'd0 || en !== 0) $display("FAIL lw_misalign: got e=%b v=%h en=%0d want 1 0 0", e, v, en); else passes++;
`else
    checks++; if (e !== 1'b0 || v !== 32'hCAFE_F00D || ra !== 32'h100)
      $display("FAIL lw_misalign: got e=%b v=%h ra=%h want 0 cafef00d 00000100", e, v, ra);
    else passes++;
`endif
  endtask

  task automatic test_timeout();
    logic r, e, pv, pr; int lat, en; logic [31:0] v, ra;
    do_load(32'h200, 3'd2, 32'h5555_AAAA, 99, r, lat, en, v, e, ra, pv, pr);
    checks++; if (en !== TO || e !== 1'b1 || v !== 32'd0 || lat !== TO + 1)
      $display("FAIL timeout: got en=%0d e=%b v=%h lat=%0d want %0d 1 0 %0d", en, e, v, lat, TO, TO + 1);
    else passes++;
    do_load(32'h204, 3'd2, 32'h5555_AAAA, TO - 1, r, lat, en, v, e, ra, pv, pr);
    checks++; if (e !== 1'b0 || v !== 32'h5555_AAAA || en !== TO)
      $display("FAIL ready_on_last: got e=%b v=%h en=%0d want 0 5555aaaa %0d", e, v, en, TO);
    else passes++;
  endtask

  task automatic test_random();
    logic r, e, pv, pr, xe; int lat, en, xlat, xen, dly; logic [31:0] a, w, v, ra, xv; logic [2:0] f;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; w = $urandom; f = 3'($urandom_range(0, 7)); dly = $urandom_range(0, TO + 1);
      do_load(a, f, w, dly, r, lat, en, v, e, ra, pv, pr);
      model(a, f, w, dly, xv, xe, xlat, xen);
      checks++; if (r !== 1'b1) $display("FAIL rnd_ready[%0d]: got %b want 1", i, r); else passes++;
      checks++; if (v !== xv || e !== xe)
        $display("FAIL rnd_value[%0d] a=%h f=%0d: got %h/%b want %h/%b", i, a, f, v, e, xv, xe);
      else passes++;
      checks++; if (lat !== xlat || en !== xen)
        $display("FAIL rnd_timing[%0d]: got lat %0d en %0d want %0d %0d", i, lat, en, xlat, xen);
      else passes++;
      if (xen > 0) begin
        checks++; if (ra !== {a[31:2], 2'b00}) $display("FAIL rnd_addr[%0d]: got %h want %h", i, ra, {a[31:2], 2'b00}); else passes++;
      end
      checks++; if (pv !== 1'b0 || pr !== 1'b1) $display("FAIL rnd_pulse[%0d]: got %b%b want 01", i, pv, pr); else passes++;
    end
  endtask

  task automatic test_reset_mid_access();
    bit seen = 0;
    @(negedge clock);
    req_valid = 1'b1; req_address = 32'h300; req_funct3 = 3'd2; mem_read_ready = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    checks++; if (mem_read_enable !== 1'b1) $display("FAIL mid_access_en: got %b want 1", mem_read_enable); else passes++;
    reset = 1'b1;
    @(negedge clock);
    checks++; if ({req_ready, mem_read_enable, rsp_valid} !== 3'b100)
      $display("FAIL reset_abort: got %b want 100", {req_ready, mem_read_enable, rsp_valid});
    else passes++;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (rsp_valid || mem_read_enable) seen = 1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL reset_no_rsp: got %b want 0", seen); else passes++;
  endtask

  task automatic test_back_to_back();
    int last = -1, pulses = 0, bad_gap = 0, ready_busy = 0;
    @(negedge clock);
    req_valid = 1'b1; req_funct3 = 3'd2; req_address = 32'h400;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      mem_read_ready = mem_read_enable;
      mem_read_value = $urandom;
      if (req_ready && (mem_read_enable || rsp_valid)) ready_busy++;
      if (rsp_valid) begin
        if (last >= 0 && c - last != 3) bad_gap++;
        last = c; pulses++;
      end
    end
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      mem_read_ready = mem_read_enable;
    end
    mem_read_ready = 1'b0;
    checks++; if (pulses < 9 || bad_gap != 0) $display("FAIL b2b_rate: got %0d pulses %0d bad gaps want >=9 0", pulses, bad_gap); else passes++;
    checks++; if (ready_busy != 0) $display("FAIL b2b_ready: got %0d busy-ready cycles want 0", ready_busy); else passes++;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    test_reset();
    test_directed();
    test_timeout();
    test_random();
    test_reset_mid_access();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
